// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver producing a byte plus one-cycle done strobe, with framing-error and busy flags
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] UART_DATA,
  output logic       UART_DONE,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] shreg_q, shreg_d, data_q, data_d;
  logic done_q, done_d, ferr_q, ferr_d, busy_q, busy_d;
  logic [1:0] sync_q, sync_d, vld_q, vld_d;
  logic armed_q, armed_d;
  logic rx_s, at_last, at_half;
  assign UART_DATA = data_q;
  assign UART_DONE = done_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
  // next-state logic; armed_q blocks a start until a real synchronized high has been seen after reset
  always_comb begin
    sync_d  = {sync_q[0], rx_serial};
    rx_s    = sync_q[1];
    vld_d   = {vld_q[0], 1'b1};
    armed_d = armed_q | (vld_q[1] & rx_s);
    at_last = cnt_q == LAST;
    at_half = cnt_q == HALF_M1;
    state_d = state_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE:  state_d = (armed_q && !rx_s) ? START : IDLE;
      START: if (at_half) begin
        state_d = rx_s ? IDLE : DATA;
        bidx_d  = 3'd0;
      end
      DATA:  if (at_last) begin
        shreg_d[bidx_q] = rx_s;
        bidx_d  = bidx_q + 3'd1;
        state_d = (bidx_q == 3'd7) ? STOP : DATA;
      end
      STOP:  if (at_last) begin
        state_d = rx_s ? IDLE : BRK;
        done_d  = rx_s;
        ferr_d  = !rx_s;
        data_d  = rx_s ? shreg_q : data_q;
      end
      BRK:   state_d = rx_s ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
    cnt_d  = (state_d != state_q || at_last) ? '0 : cnt_q + CW'(1);
    busy_d = state_d != IDLE;
  end
  // state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      sync_q  <= 2'b11;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      armed_q <= armed_d;
    end
  end
endmodule
